// File: rtl/axi_pkg.sv
// Shared AXI constants and the slave state encoding.
// Burst and response codes are common to this slave and the cache-to-AXI bridge.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        WB   = 2'd3
    } state_t;

endpackage

// File: rtl/axi_burst_next_addr.sv
// Next-beat address for an AXI burst.
// Ports:
//   addr      in  32  current beat address
//   size      in  3   log2 of bytes per beat
//   burst     in  2   burst type
//   next_addr out 32  address of the following beat
//   bad_burst out 1   reserved burst type (address then held fixed)
module axi_burst_next_addr
    import axi_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr,
    output logic        bad_burst
);

    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        next_addr = addr;
        bad_burst = 1'b0;
        case (burst)
            BURST_FIXED: next_addr = addr;
            // WRAP is served as a plain incrementing burst.
            BURST_INCR,
            BURST_WRAP:  next_addr = addr + (32'd1 << size);
            default:     bad_burst = 1'b1;
        endcase
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave serving single and burst transactions from an internal
// word-organised RAM, one transaction at a time.
// Ports:
//   clk, resetn                    clock, asynchronous active-low reset
//   ar* / arvalid / arready        read address channel
//   rid rdata rresp rlast rvalid / rready   read data channel
//   aw* / awvalid / awready        write address channel
//   wid wdata wstrb wlast wvalid / wready   write data channel (wid ignored)
//   bid bresp bvalid / bready      write response channel
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int    MEM_WORDS = 65536,
    parameter int    MEM_AW    = $clog2(MEM_WORDS),
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    state_t      state;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  beat_cnt;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        rr_last;   // last contested grant went to AR, so prefer AW
    logic        rd_prime;  // first RD cycle: address settles before the RAM read

    logic [31:0] next_addr;
    logic        bad_burst;
    logic        offer_ar;
    logic        ar_hs, aw_hs, rd_fire, wr_fire;
    logic [MEM_AW-1:0] mem_idx;

    logic [31:0] mem [MEM_WORDS];

    logic unused_wid;
    assign unused_wid = ^wid;

    // Higher address bits are dropped, so addresses alias modulo the RAM size.
    assign mem_idx = addr[MEM_AW+1:2];

    axi_burst_next_addr u_next_addr (
        .addr      (addr),
        .size      (size),
        .burst     (burst),
        .next_addr (next_addr),
        .bad_burst (bad_burst)
    );

    always_comb begin
        if (arvalid && !awvalid)      offer_ar = 1'b1;
        else if (!arvalid && awvalid) offer_ar = 1'b0;
        else                          offer_ar = !rr_last;
        ar_hs   = (state == IDLE) && arvalid && arready;
        aw_hs   = (state == IDLE) && awvalid && awready;
        // Output stage advances when empty or drained, until the last beat is out.
        rd_fire = (state == RD) && !rd_prime && !(rvalid && rlast) && (!rvalid || rready);
        wr_fire = (state == WR) && wvalid && wready;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            arready  <= 1'b0;
            awready  <= 1'b0;
            wready   <= 1'b0;
            rvalid   <= 1'b0;
            bvalid   <= 1'b0;
            rlast    <= 1'b0;
            rid      <= '0;
            bid      <= '0;
            rresp    <= RESP_OKAY;
            bresp    <= RESP_OKAY;
            rr_last  <= 1'b0;
            rd_prime <= 1'b0;
            id       <= '0;
            addr     <= '0;
            beat_cnt <= '0;
            size     <= '0;
            burst    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        id       <= arid;
                        addr     <= araddr;
                        beat_cnt <= arlen;
                        size     <= arsize;
                        burst    <= arburst;
                        arready  <= 1'b0;
                        awready  <= 1'b0;
                        rd_prime <= 1'b1;
                        if (awvalid) rr_last <= 1'b1;
                        state    <= RD;
                    end else if (aw_hs) begin
                        id       <= awid;
                        addr     <= awaddr;
                        beat_cnt <= awlen;
                        size     <= awsize;
                        burst    <= awburst;
                        arready  <= 1'b0;
                        awready  <= 1'b0;
                        wready   <= 1'b1;
                        bresp    <= RESP_OKAY;
                        if (arvalid) rr_last <= 1'b0;
                        state    <= WR;
                    end else begin
                        arready <= offer_ar;
                        awready <= !offer_ar;
                    end
                end
                RD: begin
                    rd_prime <= 1'b0;
                    if (rvalid && rready && rlast) begin
                        rvalid  <= 1'b0;
                        rlast   <= 1'b0;
                        // Offer the next address straight away for back-to-back grants.
                        arready <= offer_ar;
                        awready <= !offer_ar;
                        state   <= IDLE;
                    end else if (rd_fire) begin
                        rvalid   <= 1'b1;
                        rid      <= id;
                        rresp    <= bad_burst ? RESP_SLVERR : RESP_OKAY;
                        rlast    <= (beat_cnt == 8'd0);
                        addr     <= next_addr;
                        beat_cnt <= beat_cnt - 8'd1;
                    end
                end
                WR: begin
                    if (wr_fire) begin
                        // awlen alone sets the burst length; a wlast disagreeing with it is flagged.
                        if ((wlast != (beat_cnt == 8'd0)) || bad_burst) bresp <= RESP_SLVERR;
                        addr <= next_addr;
                        if (beat_cnt == 8'd0) begin
                            wready <= 1'b0;
                            bvalid <= 1'b1;
                            bid    <= id;
                            state  <= WB;
                        end else begin
                            beat_cnt <= beat_cnt - 8'd1;
                        end
                    end
                end
                WB: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        bresp   <= RESP_OKAY;
                        arready <= offer_ar;
                        awready <= !offer_ar;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: RAM and its read register carry no reset; contents survive resetn
    // and wready/rd_fire gating already stops accesses during reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[mem_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (rd_fire) rdata <= mem[mem_idx];
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: bursts, strobes, back-pressure,
// arbitration, wlast/burst errors and asynchronous reset mid-burst.
module tb_axi_sram_slave;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, awvalid, awready;
    logic        rlast, rvalid, rready;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready, bvalid, bready;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] wd [8];
    logic [31:0] ed [8];
    bit          grants [$];
    int          fc, ec;

    always #5 clk = ~clk;

    axi_sram_slave dut (
        .clk(clk), .resetn(resetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    // Address grant order, 0 = AR, 1 = AW.
    always @(negedge clk) begin
        if (resetn) begin
            if (arvalid && arready) grants.push_back(1'b0);
            if (awvalid && awready) grants.push_back(1'b1);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bu);
        arid = id; araddr = a; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (arready) break;
        end
        check("ar_accept", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bu);
        awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (awready) break;
        end
        check("aw_accept", awready, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic w_send(input int n, input logic [3:0] strb, input logic [15:0] last_mask);
        for (int i = 0; i < n; i++) begin
            wdata = wd[i]; wstrb = strb; wlast = last_mask[i]; wvalid = 1'b1;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (wready) break;
            end
            check($sformatf("w_accept[%0d]", i), wready, 1);
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_recv(input logic [3:0] eid, input logic [1:0] eresp);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bvalid) break;
        end
        check("bvalid", bvalid, 1);
        check("bid", bid, eid);
        check("bresp", bresp, eresp);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check("bvalid_drop", bvalid, 0);
    endtask

    task automatic write_txn(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                             input logic [2:0] sz, input logic [1:0] bu, input logic [3:0] strb,
                             input logic [15:0] last_mask, input logic [1:0] eresp);
        aw_send(id, a, len, sz, bu);
        w_send(int'(len) + 1, strb, last_mask);
        b_recv(id, eresp);
    endtask

    // Collects n beats with rready following pat (bit cyc%16), comparing against ed[].
    task automatic read_beats(input int n, input logic [15:0] pat, input logic [3:0] eid,
                              input logic [1:0] eresp, output int first_cyc, output int end_cyc);
        int got = 0;
        int cyc = 0;
        logic held = 1'b0;
        logic [31:0] held_d = '0;
        first_cyc = -1;
        while (got < n && cyc < 200) begin
            @(negedge clk);
            rready = pat[cyc % 16];
            if (rvalid && first_cyc < 0) first_cyc = cyc;
            if (held) check($sformatf("rdata_stall_stable[%0d]", got), rdata, held_d);
            if (rvalid && rready) begin
                check($sformatf("rdata[%0d]", got), rdata, ed[got]);
                check($sformatf("rlast[%0d]", got), rlast, (got == n - 1));
                check($sformatf("rid[%0d]", got), rid, eid);
                check($sformatf("rresp[%0d]", got), rresp, eresp);
                got++;
                held = 1'b0;
            end else if (rvalid) begin
                held = 1'b1;
                held_d = rdata;
            end else begin
                held = 1'b0;
            end
            cyc++;
        end
        end_cyc = cyc;
        check("r_beat_count", got, n);
        @(posedge clk); #1;
        rready = 1'b0;
        check("rvalid_after_last", rvalid, 0);
    endtask

    initial begin
        resetn = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        rready = 1'b0; bready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_arready", arready, 0);
        check("rst_awready", awready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_wready", wready, 0);
        check("rst_rlast", rlast, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("idle_offer_arready", arready, 1);
        check("idle_offer_awready", awready, 0);

        // Preload mem[0x40..0x47] through the write channel.
        for (int i = 0; i < 8; i++) wd[i] = 32'hDA7A_0000 + i;
        write_txn(4'd1, 32'h100, 8'd7, 3'd2, BURST_INCR, 4'hF, 16'h0080, RESP_OKAY);

        // INCR burst, rready high: 4 beats on consecutive cycles, first at T+2.
        for (int i = 0; i < 4; i++) ed[i] = 32'hDA7A_0000 + i;
        ar_send(4'd5, 32'h100, 8'd3, 3'd2, BURST_INCR);
        read_beats(4, 16'hFFFF, 4'd5, RESP_OKAY, fc, ec);
        check("r_first_latency", fc, 2);
        check("r_back_to_back_end", ec, 6);

        // Byte-lane write: only byte1 of mem[0x81] changes.
        wd[0] = 32'hAABB_CCDD;
        write_txn(4'd2, 32'h204, 8'd0, 3'd2, BURST_INCR, 4'hF, 16'h0001, RESP_OKAY);
        wd[0] = 32'h1122_3344;
        write_txn(4'd7, 32'h204, 8'd0, 3'd0, BURST_INCR, 4'b0010, 16'h0001, RESP_OKAY);
        ed[0] = 32'hAABB_33DD;
        ar_send(4'd3, 32'h204, 8'd0, 3'd2, BURST_INCR);
        read_beats(1, 16'hFFFF, 4'd3, RESP_OKAY, fc, ec);

        // Back-pressure 1,0,0,1,...: no lost or duplicated beats, data held.
        for (int i = 0; i < 4; i++) ed[i] = 32'hDA7A_0000 + i;
        ar_send(4'd6, 32'h100, 8'd3, 3'd2, BURST_INCR);
        read_beats(4, 16'h9249, 4'd6, RESP_OKAY, fc, ec);

        // Both address channels held valid: grants alternate starting with AR.
        grants.delete();
        arid = 4'd1; araddr = 32'h100; arlen = 8'd0; arsize = 3'd2; arburst = BURST_INCR;
        awid = 4'd2; awaddr = 32'h500; awlen = 8'd0; awsize = 3'd2; awburst = BURST_INCR;
        wdata = '0; wstrb = 4'h0; wlast = 1'b1; wvalid = 1'b1;
        rready = 1'b1; bready = 1'b1;
        arvalid = 1'b1; awvalid = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        arvalid = 1'b0; awvalid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        wvalid = 1'b0; wlast = 1'b0; rready = 1'b0; bready = 1'b0;
        check("arb_grant_count", (grants.size() >= 6), 1);
        if (grants.size() > 0) check("arb_first_is_ar", grants[0], 0);
        for (int i = 1; i < grants.size(); i++)
            check($sformatf("arb_alternate[%0d]", i), (grants[i] != grants[i-1]), 1);

        // Early wlast: all 4 beats still written, bresp SLVERR.
        for (int i = 0; i < 4; i++) wd[i] = 32'h5000_0000 + i;
        write_txn(4'd4, 32'h300, 8'd3, 3'd2, BURST_INCR, 4'hF, 16'h0002, RESP_SLVERR);
        for (int i = 0; i < 4; i++) ed[i] = 32'h5000_0000 + i;
        ar_send(4'd4, 32'h300, 8'd3, 3'd2, BURST_INCR);
        read_beats(4, 16'hFFFF, 4'd4, RESP_OKAY, fc, ec);

        // Reserved burst: address held, SLVERR on every beat.
        ed[0] = 32'hDA7A_0000; ed[1] = 32'hDA7A_0000;
        ar_send(4'd9, 32'h100, 8'd1, 3'd2, 2'b11);
        read_beats(2, 16'hFFFF, 4'd9, RESP_SLVERR, fc, ec);

        // FIXED burst repeats one word.
        for (int i = 0; i < 3; i++) ed[i] = 32'hDA7A_0002;
        ar_send(4'd1, 32'h108, 8'd2, 3'd2, BURST_FIXED);
        read_beats(3, 16'hFFFF, 4'd1, RESP_OKAY, fc, ec);

        // Upper address bits alias onto the same word.
        ed[0] = 32'hDA7A_0000;
        ar_send(4'd2, 32'h0004_0100, 8'd0, 3'd2, BURST_INCR);
        read_beats(1, 16'hFFFF, 4'd2, RESP_OKAY, fc, ec);

        // Asynchronous reset during an 8-beat read, then a clean restart.
        ar_send(4'd8, 32'h100, 8'd7, 3'd2, BURST_INCR);
        rready = 1'b1;
        begin
            int got = 0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (rvalid && rready) got++;
                if (got == 2) break;
            end
            check("rst_pre_beats", got, 2);
        end
        @(posedge clk); #2;
        check("rst_pre_rvalid", rvalid, 1);
        resetn = 1'b0;
        #1;
        check("rst_async_rvalid", rvalid, 0);
        check("rst_async_rlast", rlast, 0);
        check("rst_async_rid", rid, 0);
        check("rst_async_arready", arready, 0);
        rready = 1'b0;
        #20;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("rst_release_arready", arready, 1);
        ed[0] = 32'hDA7A_0001;
        ar_send(4'd10, 32'h104, 8'd0, 3'd2, BURST_INCR);
        read_beats(1, 16'hFFFF, 4'd10, RESP_OKAY, fc, ec);
        check("rst_restart_latency", fc, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
